fetch: RTL and testbench

- Instruction fetch stage; it drives the producer end of the if_de_cword interface that the decode stage consumes.
- Holds the PC and issues word requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned instructions in a small FIFO so that decode stalls never lose data.
- Discards stale responses after a redirect from execute (branch, JAL or JALR).

---
 rtl/fetch_pkg.sv | 41 ++++
 rtl/fetch_if.sv | 11 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch.sv | 139 +++++++++++++
 tb/tb_fetch.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its consumers.
// rvga_cword is the decode control word; fetch fills only pc and inst.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        is_branch;
        logic        is_jump;
        logic        is_load;
        logic        is_store;
    } rvga_cword;

    function automatic rvga_cword cword_from_entry(input fetch_entry_t e);
        rvga_cword cw;
        cw      = '0;
        cw.pc   = e.pc;
        cw.inst = e.inst;
        return cw;
    endfunction

    function automatic rvga_cword bubble_cword();
        rvga_cword cw;
        cw      = '0;
        cw.inst = NOP_INST;
        return cw;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/response bus: req/gnt handshake, in-order rvalid responses.
interface fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small first-word-fall-through buffer of fetched instructions.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;
    logic [DEPTH-1:0] slot_we;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop & ~flush & ~empty;
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = mem[rd_ptr_reg];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign slot_we[gi] = do_push & (wr_ptr_reg == PW'(gi));
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) mem[i] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, stale-response dropping
// after redirects, and a stall-tolerant output register feeding decode.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           stall,
    input  logic           redirect,
    input  logic [31:0]    redirect_pc,
    fetch_if.master        imem,
    output rvga_cword      if_de_cword,
    output logic           if_de_valid
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
    rvga_cword     cword_reg, cword_next;
    logic          valid_reg, valid_next;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    fetch_entry_t  fifo_head;
    fetch_entry_t  rsp_entry;
    logic          grant;
    logic          deliver;
    logic          bypass;
    logic          fifo_push;
    logic          fifo_pop;
    logic [CW:0]   credit_used;
    logic [CW:0]   drop_sum;
    logic [31:0]   redirect_target;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    // Buffered plus in-flight words may never exceed the buffer, so every response has a slot.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    assign imem.req    = ~redirect & (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem.addr   = pc_reg;

    assign grant     = imem.req & imem.gnt;
    assign deliver   = imem.rvalid & (drop_cnt_reg == '0) & ~redirect;
    assign bypass    = deliver & fifo_empty & ~stall;
    assign fifo_push = deliver & ~bypass;
    assign fifo_pop  = ~stall & ~fifo_empty;
    assign rsp_entry = '{pc: rsp_pc_reg, inst: imem.rdata};

    // Every in-flight word becomes stale on redirect; an rvalid consumed this cycle is one fewer.
    assign drop_sum = {1'b0, drop_cnt_reg} + {1'b0, outstanding_reg} - (CW+1)'(imem.rvalid);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (fifo_push),
        .din   (rsp_entry),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        pc_next          = pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        outstanding_next = outstanding_reg;
        drop_cnt_next    = drop_cnt_reg;
        if (redirect) begin
            pc_next          = redirect_target;
            rsp_pc_next      = redirect_target;
            outstanding_next = '0;
            drop_cnt_next    = drop_sum[CW-1:0];
        end else begin
            if (grant)   pc_next     = pc_reg + 32'd4;
            if (deliver) rsp_pc_next = rsp_pc_reg + 32'd4;
            outstanding_next = outstanding_reg + CW'(grant) - CW'(deliver);
            if (imem.rvalid && drop_cnt_reg != '0) drop_cnt_next = drop_cnt_reg - CW'(1);
        end
    end

    always_comb begin
        cword_next = cword_reg;
        valid_next = valid_reg;
        if (redirect) begin
            valid_next      = 1'b0;
            cword_next.inst = NOP_INST;
        end else if (!stall) begin
            if (!fifo_empty) begin
                cword_next = cword_from_entry(fifo_head);
                valid_next = 1'b1;
            end else if (deliver) begin
                cword_next = cword_from_entry(rsp_entry);
                valid_next = 1'b1;
            end else begin
                valid_next      = 1'b0;
                cword_next.inst = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            cword_reg       <= bubble_cword();
            valid_reg       <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            cword_reg       <= cword_next;
            valid_reg       <= valid_next;
        end
    end

    assign if_de_cword = cword_reg;
    assign if_de_valid = valid_reg;

    assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

    assert property (@(posedge clk) disable iff (!rst_n)
        !redirect || (drop_sum <= (CW+1)'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: streaming, stall back-pressure, async reset,
// redirects with stale-response dropping, and stall+redirect bubbles.
`timescale 1ns/1ps
module tb_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    rvga_cword   if_de_cword;
    logic        if_de_valid;

    fetch_if imem ();

    fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .if_de_cword (if_de_cword),
        .if_de_valid (if_de_valid)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        rsp_en;
    logic        seq_chk;
    logic [31:0] exp_pc;
    logic [31:0] mem_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] rest_bits(input rvga_cword cw);
        cw.pc   = '0;
        cw.inst = '0;
        return (cw != '0) ? 32'd1 : 32'd0;
    endfunction

    // One clock: note the grant, consume the output, then play memory for the next cycle.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        #1;
        g = imem.req & imem.gnt;
        a = imem.addr;
        if (seq_chk && if_de_valid && !stall) begin
            $display("cyc %0d decode takes pc=%h inst=%h", cyc, if_de_cword.pc, if_de_cword.inst);
            chk("seq_pc", if_de_cword.pc, exp_pc);
            chk("seq_inst", if_de_cword.inst, exp_pc ^ 32'hA5A5_0000);
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        if (g) mem_q.push_back(a);
        if (rsp_en && mem_q.size() > 0) begin
            imem.rvalid = 1'b1;
            imem.rdata  = mem_q.pop_front() ^ 32'hA5A5_0000;
        end else begin
            imem.rvalid = 1'b0;
            imem.rdata  = '0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_q.delete();
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        rsp_en      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        imem.gnt = 1'b1;
        seq_chk  = 1'b0;
        exp_pc   = '0;
        do_reset();

        // Reset state and first-request / first-response latency
        #1;
        chk("rst_valid", 32'(if_de_valid), 0);
        chk("rst_inst", if_de_cword.inst, 32'h0000_0013);
        chk("rst_pc", if_de_cword.pc, 32'h0);
        chk("rst_rest", rest_bits(if_de_cword), 0);
        chk("rst_req", 32'(imem.req), 1);
        chk("c0_addr", imem.addr, 32'h0);
        seq_chk = 1'b1;
        tick();
        chk("c1_addr", imem.addr, 32'h4);
        chk("c1_valid", 32'(if_de_valid), 0);
        tick();
        chk("c2_valid", 32'(if_de_valid), 1);
        chk("c2_pc", if_de_cword.pc, 32'h0);
        chk("c2_inst", if_de_cword.inst, 32'hA5A5_0000);
        chk("c2_rest", rest_bits(if_de_cword), 0);
        chk("c2_addr", imem.addr, 32'h8);
        for (int k = 2; k < 6; k++) begin
            chk("stream_valid", 32'(if_de_valid), 1);
            tick();
        end

        // Stall five cycles: output holds, credit throttles requests
        stall = 1'b1;
        for (int k = 6; k <= 10; k++) begin
            #1;
            chk("hold_valid", 32'(if_de_valid), 1);
            chk("hold_pc", if_de_cword.pc, 32'h10);
            chk("hold_inst", if_de_cword.inst, 32'hA5A5_0010);
            if (k >= 7) chk("credit_req", 32'(imem.req), 0);
            tick();
        end
        stall = 1'b0;
        for (int k = 11; k <= 16; k++) begin
            chk("resume_valid", 32'(if_de_valid), 1);
            tick();
        end
        chk("seq_cnt", exp_pc, 32'h28);
        seq_chk = 1'b0;

        // Fill the FIFO, then async reset mid-cycle
        stall = 1'b1;
        tick();
        tick();
        #1;
        chk("full_req", 32'(imem.req), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(if_de_valid), 0);
        chk("arst_inst", if_de_cword.inst, 32'h0000_0013);
        chk("arst_pc", if_de_cword.pc, 32'h0);
        chk("arst_addr", imem.addr, 32'h0);
        do_reset();
        #1;
        chk("rel_addr", imem.addr, 32'h0);
        chk("rel_valid0", 32'(if_de_valid), 0);
        tick();
        chk("rel_valid1", 32'(if_de_valid), 0);
        tick();
        chk("rel_valid2", 32'(if_de_valid), 1);
        chk("rel_pc", if_de_cword.pc, 32'h0);

        // Two requests in flight (0x10, 0x14), redirect to 0x103
        tick();
        tick();
        rsp_en = 1'b0;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        chk("redir_req", 32'(imem.req), 0);
        rsp_en = 1'b1;
        tick();
        redirect = 1'b0;
        #1;
        chk("redir_addr", imem.addr, 32'h100);
        chk("redir_req1", 32'(imem.req), 1);
        chk("redir_bubble", 32'(if_de_valid), 0);
        chk("redir_nop", if_de_cword.inst, 32'h0000_0013);
        tick();
        chk("drop1_valid", 32'(if_de_valid), 0);
        tick();
        chk("drop2_valid", 32'(if_de_valid), 0);
        tick();
        chk("tgt_valid", 32'(if_de_valid), 1);
        chk("tgt_pc", if_de_cword.pc, 32'h100);
        chk("tgt_inst", if_de_cword.inst, 32'hA5A5_0100);
        tick();
        chk("tgt_pc2", if_de_cword.pc, 32'h104);

        // Redirect in the same cycle as an rvalid, one more outstanding
        rsp_en = 1'b0;
        tick();
        rsp_en = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        #1;
        chk("rv_addr", imem.addr, 32'h200);
        chk("rv_valid0", 32'(if_de_valid), 0);
        tick();
        chk("rv_valid1", 32'(if_de_valid), 0);
        tick();
        chk("rv_valid2", 32'(if_de_valid), 1);
        chk("rv_pc", if_de_cword.pc, 32'h200);
        chk("rv_inst", if_de_cword.inst, 32'hA5A5_0200);
        tick();
        chk("rv_pc2", if_de_cword.pc, 32'h204);

        // Stall with redirect, then a back-to-back redirect
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        #1;
        chk("sr_valid", 32'(if_de_valid), 0);
        chk("sr_nop", if_de_cword.inst, 32'h0000_0013);
        stall       = 1'b0;
        redirect_pc = 32'h0000_0400;
        tick();
        redirect = 1'b0;
        #1;
        chk("b2b_req", 32'(imem.req), 1);
        chk("b2b_addr", imem.addr, 32'h400);
        tick();
        chk("b2b_valid1", 32'(if_de_valid), 0);
        tick();
        chk("b2b_valid2", 32'(if_de_valid), 1);
        chk("b2b_pc", if_de_cword.pc, 32'h400);
        chk("b2b_inst", if_de_cword.inst, 32'hA5A5_0400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
